mine_game_ctrl: RTL and testbench



---
 rtl/ms_pkg.sv | 29 ++
 rtl/ms_lfsr.sv | 22 ++
 rtl/mine_game_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mine_game_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// Shared key codes, FSM states and win/lose encodings for the minesweeper controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ms_pkg;

    localparam logic [2:0] UP      = 3'd0;
    localparam logic [2:0] DOWN    = 3'd1;
    localparam logic [2:0] LEFT    = 3'd2;
    localparam logic [2:0] RIGHT   = 3'd3;
    localparam logic [2:0] REVEAL  = 3'd4;
    localparam logic [2:0] FLAG    = 3'd5;
    localparam logic [2:0] RESTART = 3'd6;

    typedef enum logic [2:0] {
        S_READY = 3'd0,
        S_PLACE = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    localparam logic [1:0] WL_PLAY = 2'b00;
    localparam logic [1:0] WL_WIN  = 2'b01;
    localparam logic [1:0] WL_LOSE = 2'b10;

    // Galois feedback mask for taps 16/14/13/11 (maximal length)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ms_lfsr.sv
// 16-bit Galois LFSR, free-running, used to pick mine candidates.
// Latency: output is the registered state, advances every cycle.
// Backpressure: none; never stalls.
module ms_lfsr
    import ms_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr
);

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/mine_game_ctrl.sv
// Minesweeper game controller for a GRID_W x GRID_H board; MS_FLAG_EN enables flag storage.
// Latency: key events take effect on the sampling edge; mine placement takes >= MINES cycles.
// Backpressure: none; keys other than RESTART are dropped while busy (S_PLACE).
module mine_game_ctrl
    import ms_pkg::*;
#(
    parameter int          GRID_W    = 8,
    parameter int          GRID_H    = 8,
    parameter int          MINES     = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         N         = GRID_W * GRID_H,
    localparam int         XW        = (GRID_W > 2) ? $clog2(GRID_W) : 1,
    localparam int         YW        = (GRID_H > 2) ? $clog2(GRID_H) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [2:0]    key_code,
    output logic [1:0]    wl,
    output logic [N-1:0]  bomb_grid,
    output logic [N-1:0]  reveal_grid,
    output logic [N-1:0]  flag_grid,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic [2:0]    state,
    output logic          busy
);

    localparam int            IW      = $clog2(N);
    localparam int            CW      = $clog2(N + 1);
    localparam logic [XW:0]   GW_L    = (XW + 1)'(GRID_W);
    localparam logic [YW:0]   GH_L    = (YW + 1)'(GRID_H);
    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [CW-1:0] MINES_L = CW'(MINES);
    localparam logic [CW-1:0] SAFE_N  = CW'(N - MINES);

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(32'(y) * 32'(GRID_W) + 32'(x));
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    wl_q, wl_d;
    logic [N-1:0]  bomb_q, bomb_d;
    logic [N-1:0]  reveal_q, reveal_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [IW-1:0] safe_q, safe_d;
    logic [15:0]   lfsr_q;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic [IW-1:0] cand_idx, cur_idx;
    logic          cand_ok, cur_flag;

    ms_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr_q)
    );

    generate
        if (XW + YW < 16) begin : g_spare_bits
            logic unused_lfsr_bits;
            assign unused_lfsr_bits = ^lfsr_q[15:XW+YW];
        end
    endgenerate

    assign cand_x   = lfsr_q[XW-1:0];
    assign cand_y   = lfsr_q[XW+YW-1:XW];
    assign cand_idx = cell_idx(cand_x, cand_y);
    assign cur_idx  = cell_idx(cx_q, cy_q);
    assign cand_ok  = ({1'b0, cand_x} < GW_L) && ({1'b0, cand_y} < GH_L) &&
                      !bomb_q[cand_idx] && (cand_idx != safe_q);

`ifdef MS_FLAG_EN
    logic [N-1:0] flag_q, flag_d;
    assign flag_grid = flag_q;
    assign cur_flag  = flag_q[cur_idx];
`else
    assign flag_grid = '0;
    assign cur_flag  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_READY;
            wl_q     <= WL_PLAY;
            bomb_q   <= '0;
            reveal_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            rcnt_q   <= '0;
            pcnt_q   <= '0;
            safe_q   <= '0;
`ifdef MS_FLAG_EN
            flag_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wl_q     <= wl_d;
            bomb_q   <= bomb_d;
            reveal_q <= reveal_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            rcnt_q   <= rcnt_d;
            pcnt_q   <= pcnt_d;
            safe_q   <= safe_d;
`ifdef MS_FLAG_EN
            flag_q   <= flag_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        wl_d     = wl_q;
        bomb_d   = bomb_q;
        reveal_d = reveal_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        rcnt_d   = rcnt_q;
        pcnt_d   = pcnt_q;
        safe_d   = safe_q;
`ifdef MS_FLAG_EN
        flag_d   = flag_q;
`endif
        if (key_valid && key_code == RESTART) begin
            state_d  = S_READY;
            wl_d     = WL_PLAY;
            bomb_d   = '0;
            reveal_d = '0;
            cx_d     = '0;
            cy_d     = '0;
            rcnt_d   = '0;
            pcnt_d   = '0;
`ifdef MS_FLAG_EN
            flag_d   = '0;
`endif
        end else begin
            case (state_q)
                S_READY, S_PLAY: begin
                    if (key_valid) begin
                        case (key_code)
                            UP:    cy_d = (cy_q == '0)    ? Y_MAX : cy_q - YW'(1);
                            DOWN:  cy_d = (cy_q == Y_MAX) ? '0    : cy_q + YW'(1);
                            LEFT:  cx_d = (cx_q == '0)    ? X_MAX : cx_q - XW'(1);
                            RIGHT: cx_d = (cx_q == X_MAX) ? '0    : cx_q + XW'(1);
                            REVEAL: begin
                                if (state_q == S_READY) begin
                                    safe_d  = cur_idx;
                                    state_d = S_PLACE;
                                end else if (!reveal_q[cur_idx] && !cur_flag) begin
                                    reveal_d[cur_idx] = 1'b1;
                                    if (bomb_q[cur_idx]) begin
                                        wl_d    = WL_LOSE;
                                        state_d = S_LOSE;
                                    end else begin
                                        rcnt_d = rcnt_q + CW'(1);
                                        if (rcnt_q + CW'(1) == SAFE_N) begin
                                            wl_d    = WL_WIN;
                                            state_d = S_WIN;
                                        end
                                    end
                                end
                            end
`ifdef MS_FLAG_EN
                            FLAG: begin
                                if (state_q == S_PLAY && !reveal_q[cur_idx]) begin
                                    flag_d[cur_idx] = !flag_q[cur_idx];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_PLACE: begin
                    if (cand_ok) begin
                        bomb_d[cand_idx] = 1'b1;
                        pcnt_d           = pcnt_q + CW'(1);
                        // last mine placed: open the protected first cell immediately
                        if (pcnt_q + CW'(1) == MINES_L) begin
                            reveal_d[safe_q] = 1'b1;
                            rcnt_d           = CW'(1);
                            if (SAFE_N == CW'(1)) begin
                                wl_d    = WL_WIN;
                                state_d = S_WIN;
                            end else begin
                                state_d = S_PLAY;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wl          = wl_q;
    assign bomb_grid   = bomb_q;
    assign reveal_grid = reveal_q;
    assign cursor_x    = cx_q;
    assign cursor_y    = cy_q;
    assign state       = state_q;
    assign busy        = (state_q == S_PLACE);

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Scoreboard bench for mine_game_ctrl on a 4x4 board with 3 mines.
module tb_mine_game_ctrl;
    import ms_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int M = 3;
    localparam int N = 16;

    localparam int O_WL = 0, O_STATE = 1, O_CX = 2, O_CY = 3, O_BUSY = 4, O_BOMB = 5;
    localparam int O_BPOP = 6, O_BBIT = 7, O_REV = 8, O_RBIT = 9, O_FLAG = 10, O_FBIT = 11;

    typedef struct {
        string name;
        int    sel;
        int    idx;
        int    req;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [2:0]   key_code;
    logic [1:0]   wl;
    logic [N-1:0] bomb_grid, reveal_grid, flag_grid;
    logic [1:0]   cursor_x, cursor_y;
    logic [2:0]   state;
    logic         busy;

    exp_t  sb[$];
    exp_t  mon_r;
    int    n_checks = 0;
    int    n_errors = 0;
    int    cur_x, cur_y;
    logic [15:0] bombs, rmask;

    always #5 clock = ~clock;

    mine_game_ctrl #(.GRID_W(W), .GRID_H(H), .MINES(M), .LFSR_SEED(16'hACE1)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .wl          (wl),
        .bomb_grid   (bomb_grid),
        .reveal_grid (reveal_grid),
        .flag_grid   (flag_grid),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .state       (state),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int obs(input int sel, input int idx);
        case (sel)
            O_WL:    return int'(wl);
            O_STATE: return int'(state);
            O_CX:    return int'(cursor_x);
            O_CY:    return int'(cursor_y);
            O_BUSY:  return int'(busy);
            O_BOMB:  return int'(bomb_grid);
            O_BPOP:  return $countones(bomb_grid);
            O_BBIT:  return int'(bomb_grid[idx]);
            O_REV:   return int'(reveal_grid);
            O_RBIT:  return int'(reveal_grid[idx]);
            O_FLAG:  return int'(flag_grid);
            O_FBIT:  return int'(flag_grid[idx]);
            default: return -1;
        endcase
    endfunction

    function automatic void want(input string name, input int sel, input int idx, input int req);
        sb.push_back('{name, sel, idx, req});
    endfunction

    // Monitor: compares every queued expectation just after the edge that consumed the stimulus
    always @(posedge clock) begin
        #1;
        while (sb.size() > 0) begin
            mon_r = sb.pop_front();
            check(mon_r.name, obs(mon_r.sel, mon_r.idx), mon_r.req);
        end
    end

    task automatic press(input logic [2:0] c);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = c;
    endtask

    task automatic idle();
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic move_to(input int tx, input int ty);
        while (cur_x != tx) begin
            press(RIGHT);
            cur_x = (cur_x + 1) % W;
        end
        while (cur_y != ty) begin
            press(DOWN);
            cur_y = (cur_y + 1) % H;
        end
        idle();
        want("move_x", O_CX, 0, tx);
        want("move_y", O_CY, 0, ty);
    endtask

    task automatic want_cleared(input string tag);
        want({tag, "_state"}, O_STATE, 0, int'(S_READY));
        want({tag, "_wl"}, O_WL, 0, 0);
        want({tag, "_bomb"}, O_BOMB, 0, 0);
        want({tag, "_reveal"}, O_REV, 0, 0);
        want({tag, "_flag"}, O_FLAG, 0, 0);
        want({tag, "_cx"}, O_CX, 0, 0);
        want({tag, "_cy"}, O_CY, 0, 0);
        want({tag, "_busy"}, O_BUSY, 0, 0);
    endtask

    task automatic wait_place();
        int  n    = 1;
        bit  done = 1'b0;
        idle();
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clock);
            #2;
            if (busy) n++;
            else done = 1'b1;
        end
        check("place_done", int'(done), 1);
        check("place_len_ge_mines", int'(n >= M), 1);
        bombs = bomb_grid;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int first_safe;
        int mine;
        int cnt;
        logic [15:0] lmask;

        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = REVEAL;
        cur_x     = 0;
        cur_y     = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        key_valid = 1'b0;
        want_cleared("reset");

        for (int i = 1; i <= 5; i++) begin
            press(RIGHT);
            want("right_wrap_x", O_CX, 0, i % W);
        end
        press(LEFT);   want("left_x", O_CX, 0, 0);
        press(LEFT);   want("left_wrap_x", O_CX, 0, 3);
        press(UP);     want("up_wrap_y", O_CY, 0, 3);
        press(DOWN);   want("down_wrap_y", O_CY, 0, 0);
        press(3'd7);   want("undef_key_x", O_CX, 0, 3);
                       want("undef_key_state", O_STATE, 0, int'(S_READY));

        press(REVEAL);  want("place_enter", O_STATE, 0, int'(S_PLACE));
                        want("place_busy", O_BUSY, 0, 1);
        press(RIGHT);   want("place_drop_x", O_CX, 0, 3);
                        want("place_still_busy", O_BUSY, 0, 1);
        press(RESTART); want_cleared("restart_in_place");
        idle();
        cur_x = 0;
        cur_y = 0;

        move_to(2, 1);
        press(REVEAL);
        want("reveal_place", O_STATE, 0, int'(S_PLACE));
        want("reveal_busy", O_BUSY, 0, 1);
        wait_place();
        want("play_state", O_STATE, 0, int'(S_PLAY));
        want("mine_count", O_BPOP, 0, M);
        want("safe_not_mined", O_BBIT, 6, 0);
        want("safe_revealed", O_RBIT, 6, 1);
        want("only_safe_revealed", O_REV, 0, 16'h0040);
        want("play_wl", O_WL, 0, 0);

        first_safe = -1;
        for (int i = 0; i < N; i++)
            if (!bombs[i] && i != 6 && first_safe < 0) first_safe = i;
        move_to(first_safe % W, first_safe / W);
        press(FLAG);
`ifdef MS_FLAG_EN
        want("flag_set", O_FBIT, first_safe, 1);
        press(REVEAL);
        want("flagged_no_reveal", O_RBIT, first_safe, 0);
        want("flagged_state", O_STATE, 0, int'(S_PLAY));
        press(FLAG);
        want("flag_clear", O_FBIT, first_safe, 0);
`else
        want("flag_disabled", O_FLAG, 0, 0);
`endif
        move_to(2, 1);
        press(FLAG);
        want("flag_on_revealed", O_FLAG, 0, 0);

        rmask = 16'h0040;
        cnt   = 1;
        for (int i = 0; i < N; i++) begin
            if (!bombs[i] && i != 6) begin
                move_to(i % W, i / W);
                press(REVEAL);
                rmask[i] = 1'b1;
                cnt++;
                want("reveal_mask", O_REV, 0, int'(rmask));
                if (cnt == N - M) begin
                    want("win_wl", O_WL, 0, 1);
                    want("win_state", O_STATE, 0, int'(S_WIN));
                end else begin
                    want("play_wl_mid", O_WL, 0, 0);
                    want("play_state_mid", O_STATE, 0, int'(S_PLAY));
                end
                if (cnt == 2) begin
                    press(REVEAL);
                    want("rereveal_mask", O_REV, 0, int'(rmask));
                    want("rereveal_wl", O_WL, 0, 0);
                end
            end
        end

        press(RIGHT);  want("win_hold_x", O_CX, 0, cur_x);
        press(REVEAL); want("win_hold_rev", O_REV, 0, int'(rmask));
                       want("win_hold_state", O_STATE, 0, int'(S_WIN));
                       want("win_hold_wl", O_WL, 0, 1);
        press(FLAG);   want("win_hold_flag", O_FLAG, 0, 0);
        press(RESTART);
        want_cleared("restart_after_win");
        idle();
        cur_x = 0;
        cur_y = 0;

        press(REVEAL);
        want("lose_place", O_STATE, 0, int'(S_PLACE));
        wait_place();
        want("lose_safe0", O_BBIT, 0, 0);
        mine = -1;
        for (int i = 0; i < N; i++)
            if (bombs[i] && mine < 0) mine = i;
        move_to(mine % W, mine / W);
        press(REVEAL);
        lmask       = 16'h0001;
        lmask[mine] = 1'b1;
        want("lose_wl", O_WL, 0, 2);
        want("lose_state", O_STATE, 0, int'(S_LOSE));
        want("lose_mine_bit", O_RBIT, mine, 1);
        want("lose_mask", O_REV, 0, int'(lmask));
        press(UP);     want("lose_hold_y", O_CY, 0, cur_y);
        press(RESTART);
        want_cleared("restart_after_lose");
        idle();

        @(posedge clock);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
